mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit that sequences the shared ARM datapath: one memory port, one ALU, register file, PC and instruction register.
- Runs a per-instruction state machine (fetch/decode/execute/writeback) and owns the NZCV flag register and condition check.
- Drives all datapath enables and mux selects, with a memory-ready handshake for wait states.
- Replaces the single-cycle decoder path in the multicycle core.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Instr  in  32  IR contents; uses [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd
- ALUFlags  in  4  NZCV from ALU, current cycle
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut drives memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 const 4
- ImmSrc  out  2  extend select: 00 DP, 01 mem, 10 branch
- RegSrc  out  2  register-address mux selects
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC
- Shift  out  1  route shifter result (LSL)
- CarryIn  out  1  registered C flag, for ADC

Behaviour:
- Reset: state = FETCH; flags = RESET_FLAGS; CondExR = 0; while reset_n is low, all outputs are 0.
- States:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10. If mem_ready: IRWrite=1, PCWrite=1, go to DECODE; else hold with no strobes.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8); latch CondExR from Instr[31:28] and current flags.
  - DECODE transitions: Op=01 -> MEMADR; Op=00 with Funct[5]=1 -> EXECUTEI; Op=00 with Funct[5]=0 -> EXECUTER; Op=10 -> BRANCH; Op=11 -> FETCH (no writes).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD: AdrSrc=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegW; -> FETCH.
  - MEMWRITE: AdrSrc=1, MemW held every cycle until mem_ready; -> FETCH on mem_ready.
  - EXECUTER: ALUSrcB=00, ALU-decoder controls; -> ALUWB.
  - EXECUTEI: ALUSrcB=01, ALU-decoder controls; -> ALUWB.
  - ALUWB: ResultSrc=00, RegW; -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch; -> FETCH.
- ALU decoder (Funct[4:1]):
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1000 TST = AND with NoWrite; 1011 CMN = ADD with NoWrite.
  - 1101 LSL = ADD with Shift; 0101 ADC.
  - Unknown code: ADD, NoWrite=1, no flag write.
  - Non-DP states use ADD.
- FlagW:
  - [1] (NZ) = Funct[0] in EXECUTE states.
  - [0] (CV) = Funct[0] & ALUControl in {ADD, SUB, ADC}.
  - Flags register in the EXECUTE cycle only, gated by CondExR.
- Write gating:
  - RegWrite = RegW & CondExR & ~NoWrite.
  - MemWrite = MemW & CondExR.
  - PCWrite = NextPC | (PCS & CondExR), where PCS = Branch | (RegW & Rd==15).
- Condition codes: full 15-code evaluation (EQ..LE); AL=1110 always true; 1111 treated as false.
- Latency: DP 4 cycles, STR 4, LDR 5, B 3, plus one cycle per mem_ready=0 cycle.
- Asynchronous reset mid-instruction aborts it: no partial writes, and flags revert to RESET_FLAGS.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - ALUControl code localparams
  - ResultSrc/ALUSrcB encodings
  - condition-code enum
- Sub-module cond_unit: flag register, CondExR register, condition evaluation and write gating.

Test Plan:
- ADD R1,R2,R3 (E0821003), mem_ready=1 -> states FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in cycle 4; flags unchanged.
- SUBS R0,R0,#1 with R0=1 -> in EXECUTEI, ALUControl=001; after the cycle flags have Z=1, C=1.
- LDR (E5912004), mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; RegWrite=1 only in MEMWB with ResultSrc=01.
- BEQ with Z=0 -> PCWrite=0 in BRANCH; with Z=1 -> PCWrite=1 there, ResultSrc=10.
- STRNE with Z=1 -> MemWrite stays 0 for all cycles, FSM still returns to FETCH.
- Pulse reset_n low during MEMWRITE -> all strobes 0 immediately; FETCH on release; flags = RESET_FLAGS.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle ARM control unit
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    typedef enum logic [3:0] {
        C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
        C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
    } cond_e;

endpackage

// File: rtl/mc_controller_cond_unit.sv
// rtl/mc_controller_cond_unit.sv - NZCV flags, condition evaluation and write gating
module cond_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_cond,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       pcs,
    input  logic       next_pc,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       carry_in
);

    logic [3:0] flags;
    logic       cond_ex;
    logic       cond_ex_r;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            C_EQ: cond_ex = z;
            C_NE: cond_ex = ~z;
            C_CS: cond_ex = c;
            C_CC: cond_ex = ~c;
            C_MI: cond_ex = n;
            C_PL: cond_ex = ~n;
            C_VS: cond_ex = v;
            C_VC: cond_ex = ~v;
            C_HI: cond_ex = c & ~z;
            C_LS: cond_ex = ~c | z;
            C_GE: cond_ex = (n == v);
            C_LT: cond_ex = (n != v);
            C_GT: cond_ex = ~z & (n == v);
            C_LE: cond_ex = z | (n != v);
            C_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // The condition is sampled once in DECODE so later flag updates cannot retarget it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags     <= RESET_FLAGS;
            cond_ex_r <= 1'b0;
        end else begin
            if (latch_cond)
                cond_ex_r <= cond_ex;
            if (flag_w[1] & cond_ex_r)
                flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex_r)
                flags[1:0] <= alu_flags[1:0];
        end
    end

    assign reg_write = reg_w & cond_ex_r & ~no_write;
    assign mem_write = mem_w & cond_ex_r;
    assign pc_write  = next_pc | (pcs & cond_ex_r);
    assign carry_in  = c;

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM control FSM driving the shared datapath
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl,
    output logic        Shift,
    output logic        CarryIn
);

    state_e     state, state_next;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_instr;

    logic       next_pc, ir_write, reg_w, mem_w, branch, no_write, latch_cond;
    logic       adr_src, alu_src_a, shift;
    logic [1:0] result_src, alu_src_b, imm_src, flag_w;
    logic [2:0] alu_ctrl;
    logic       dp_shift, dp_no_write, dp_known;
    logic [2:0] dp_ctrl;
    logic       reg_write, mem_write, pc_write, carry_in;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        dp_ctrl     = ALU_ADD;
        dp_shift    = 1'b0;
        dp_no_write = 1'b0;
        dp_known    = 1'b1;
        case (funct[4:1])
            4'b0100: dp_ctrl = ALU_ADD;
            4'b0010: dp_ctrl = ALU_SUB;
            4'b0000: dp_ctrl = ALU_AND;
            4'b1100: dp_ctrl = ALU_ORR;
            4'b1000: begin dp_ctrl = ALU_AND; dp_no_write = 1'b1; end
            4'b1011: dp_no_write = 1'b1;
            4'b1101: dp_shift = 1'b1;
            4'b0101: dp_ctrl = ALU_ADC;
            default: begin dp_known = 1'b0; dp_no_write = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        next_pc    = 1'b0;
        ir_write   = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        no_write   = 1'b0;
        latch_cond = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_DP;
        alu_ctrl   = ALU_ADD;
        shift      = 1'b0;
        flag_w     = 2'b00;
        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_pc    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                latch_cond = 1'b1;
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_MEM;
                state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready)
                    state_next = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b  = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                alu_ctrl   = dp_ctrl;
                shift      = dp_shift;
                // CV only makes sense for the arithmetic ops; unknown codes leave flags alone
                flag_w     = dp_known ? {funct[0], funct[0] & (dp_ctrl == ALU_ADD ||
                             dp_ctrl == ALU_SUB || dp_ctrl == ALU_ADC)} : 2'b00;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w      = 1'b1;
                no_write   = dp_no_write;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
        .clk        (clk),
        .reset_n    (reset_n),
        .cond       (Instr[31:28]),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .latch_cond (latch_cond),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .pcs        (branch | (reg_w & (rd == 4'hF))),
        .next_pc    (next_pc),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .pc_write   (pc_write),
        .carry_in   (carry_in)
    );

    // Every output is forced low while reset is held, independent of the clock
    assign {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, RegSrc, ALUControl, Shift, CarryIn} = reset_n ?
           {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b,
            imm_src, {(op == 2'b01) & ~funct[0], op == 2'b10}, alu_ctrl, shift, carry_in} : '0;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - table-driven scoreboard bench for mc_controller
module tb_mc_controller;

    logic        clk, reset_n;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Shift, CarryIn;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;

    mc_controller #(.RESET_FLAGS(4'b0010)) dut (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Shift(Shift), .CarryIn(CarryIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD   = 32'hE0821003;
    localparam logic [31:0] I_UNK   = 32'hE1F01002;
    localparam logic [31:0] I_SUBS  = 32'hE2500001;
    localparam logic [31:0] I_BEQ   = 32'h0A000002;
    localparam logic [31:0] I_TST   = 32'hE1120003;
    localparam logic [31:0] I_ADCS  = 32'hE0B21003;
    localparam logic [31:0] I_ORR   = 32'hE1821003;
    localparam logic [31:0] I_LSL   = 32'hE1A01102;
    localparam logic [31:0] I_ADDPC = 32'hE082F003;
    localparam logic [31:0] I_LDR   = 32'hE5912004;
    localparam logic [31:0] I_STR   = 32'hE5812004;
    localparam logic [31:0] I_STRNE = 32'h15812004;
    localparam logic [31:0] I_OP11  = 32'hEC000000;
    localparam logic [31:0] I_CMN   = 32'hE1720003;

    typedef enum int {B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB,
                      B_MEMWRITE, B_EXR, B_EXI, B_ALUWB, B_BRANCH} bst_e;

    // strb = {PCWrite, MemWrite, IRWrite, RegWrite}
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        logic        rdy;
        bst_e        st;
        logic [3:0]  strb;
        logic [2:0]  aluc;
        logic        shift;
        logic        carry;
    } vec_t;

    typedef struct {
        logic [14:0] exp;
        logic [14:0] care;
        int          idx;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   split;

    task automatic v(input logic [31:0] instr, input logic [3:0] fl, input logic rdy,
                     input bst_e st, input logic [3:0] strb, input logic [2:0] aluc,
                     input logic sh, input logic c);
        vec_t r;
        r.instr = instr; r.flags = fl; r.rdy = rdy; r.st = st;
        r.strb = strb; r.aluc = aluc; r.shift = sh; r.carry = c;
        tbl.push_back(r);
    endtask

    task automatic dp(input logic [31:0] instr, input logic [3:0] xf, input logic imm,
                      input logic [2:0] aluc, input logic sh, input logic c_ex,
                      input logic c_wb, input logic [3:0] wb_strb);
        v(instr, 4'hF, 1'b1, B_FETCH, 4'b1010, 3'd0, 1'b0, c_ex);
        v(instr, 4'hF, 1'b1, B_DECODE, 4'b0000, 3'd0, 1'b0, c_ex);
        v(instr, xf, 1'b1, imm ? B_EXI : B_EXR, 4'b0000, aluc, sh, c_ex);
        v(instr, 4'hF, 1'b1, B_ALUWB, wb_strb, 3'd0, 1'b0, c_wb);
    endtask

    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}: only the selects each state defines are compared
    function automatic void sel_model(input bst_e st, output logic [5:0] care,
                                      output logic [5:0] val);
        case (st)
            B_FETCH:    begin care = 6'b111111; val = 6'b010110; end
            B_DECODE:   begin care = 6'b011111; val = 6'b010110; end
            B_MEMADR:   begin care = 6'b000111; val = 6'b000001; end
            B_MEMREAD:  begin care = 6'b100000; val = 6'b100000; end
            B_MEMWB:    begin care = 6'b011000; val = 6'b001000; end
            B_MEMWRITE: begin care = 6'b100000; val = 6'b100000; end
            B_EXR:      begin care = 6'b000011; val = 6'b000000; end
            B_EXI:      begin care = 6'b000011; val = 6'b000001; end
            B_ALUWB:    begin care = 6'b011000; val = 6'b000000; end
            B_BRANCH:   begin care = 6'b011111; val = 6'b010001; end
            default:    begin care = 6'b000000; val = 6'b000000; end
        endcase
    endfunction

    task automatic check_out();
        sb_t         s;
        logic [14:0] act;
        s   = sbq.pop_front();
        act = {PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, Shift, CarryIn};
        checks++;
        if ((act & s.care) !== (s.exp & s.care)) begin
            errors++;
            $display("FAIL vec%0d st=%0d act=%b exp=%b care=%b", s.idx, tbl[s.idx].st,
                     act, s.exp, s.care);
        end
    endtask

    task automatic apply(input int i);
        sb_t        s;
        logic [5:0] sc, sv;
        Instr     = tbl[i].instr;
        ALUFlags  = tbl[i].flags;
        mem_ready = tbl[i].rdy;
        sel_model(tbl[i].st, sc, sv);
        s.exp  = {tbl[i].strb, sv, tbl[i].aluc, tbl[i].shift, tbl[i].carry};
        s.care = {4'hF, sc, 5'h1F};
        s.idx  = i;
        sbq.push_back(s);
        #2 check_out();
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        logic [21:0] all;
        all = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegSrc, ALUControl, Shift, CarryIn};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL %s outputs=%b expected all zero", nm, all);
        end
    endtask

    initial begin
        reset_n = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b1;

        dp(I_ADD,   4'hF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 4'b0001);
        dp(I_UNK,   4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 4'b0000);
        dp(I_SUBS,  4'h6, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 4'b0001);
        v(I_BEQ, 4'hF, 1'b1, B_FETCH,  4'b1010, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_DECODE, 4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_BRANCH, 4'b1000, 3'd0, 1'b0, 1'b1);
        dp(I_TST,   4'h0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 4'b0000);
        v(I_BEQ, 4'hF, 1'b1, B_FETCH,  4'b1010, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_DECODE, 4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_BRANCH, 4'b0000, 3'd0, 1'b0, 1'b1);
        dp(I_ADCS,  4'h0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 4'b0001);
        dp(I_ORR,   4'hF, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 4'b0001);
        dp(I_LSL,   4'hF, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0001);
        dp(I_ADDPC, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'b1001);
        v(I_LDR, 4'hF, 1'b0, B_FETCH,   4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b1, B_FETCH,   4'b1010, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b1, B_DECODE,  4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b1, B_MEMADR,  4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b0, B_MEMREAD, 4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b0, B_MEMREAD, 4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b1, B_MEMREAD, 4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_LDR, 4'hF, 1'b1, B_MEMWB,   4'b0001, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_FETCH,    4'b1010, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_DECODE,   4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_MEMADR,   4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b0, B_MEMWRITE, 4'b0100, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_MEMWRITE, 4'b0100, 3'd0, 1'b0, 1'b0);
        dp(I_SUBS,  4'h6, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 4'b0001);
        v(I_STRNE, 4'hF, 1'b1, B_FETCH,    4'b1010, 3'd0, 1'b0, 1'b1);
        v(I_STRNE, 4'hF, 1'b1, B_DECODE,   4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_STRNE, 4'hF, 1'b1, B_MEMADR,   4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_STRNE, 4'hF, 1'b0, B_MEMWRITE, 4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_STRNE, 4'hF, 1'b1, B_MEMWRITE, 4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_OP11, 4'hF, 1'b1, B_FETCH,  4'b1010, 3'd0, 1'b0, 1'b1);
        v(I_OP11, 4'hF, 1'b1, B_DECODE, 4'b0000, 3'd0, 1'b0, 1'b1);
        dp(I_CMN,   4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0000);
        v(I_STR, 4'hF, 1'b1, B_FETCH,    4'b1010, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_DECODE,   4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b1, B_MEMADR,   4'b0000, 3'd0, 1'b0, 1'b0);
        v(I_STR, 4'hF, 1'b0, B_MEMWRITE, 4'b0100, 3'd0, 1'b0, 1'b0);
        split = tbl.size();
        v(I_BEQ, 4'hF, 1'b1, B_FETCH,  4'b1010, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_DECODE, 4'b0000, 3'd0, 1'b0, 1'b1);
        v(I_BEQ, 4'hF, 1'b1, B_BRANCH, 4'b0000, 3'd0, 1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        #2 check_zero("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < split; i++)
            apply(i);

        mem_ready = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_memwrite act=%b exp=1", MemWrite);
        end
        reset_n = 1'b0;
        #1 check_zero("reset_mid_store");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = split; i < tbl.size(); i++)
            apply(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
